sha3_digest_serializer: RTL and testbench

- Sits directly downstream of the state delayer at the end of the Keccak permutation pipeline.
- Captures each finished 25-lane state on its good strobe into a two-slot ping-pong buffer.
- Emits the first OUT_LANES lanes, the digest, as a stream of 64-bit words with valid/ready handshake.
- The upstream pipeline has no backpressure, so input arrivals while full are dropped and flagged with a sticky overflow.

---
 rtl/sha3_digest_serializer.sv | 122 ++++++++++++
 tb/tb_sha3_digest_serializer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_digest_serializer.sv
// rtl/sha3_digest_serializer.sv - two-slot ping-pong buffer streaming Keccak digest lanes as 64-bit words
module sha3_digest_serializer #(
  parameter int OUT_LANES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sample,
  input  logic [4:0][63:0] isa,
  input  logic [4:0][63:0] isb,
  input  logic [4:0][63:0] isc,
  input  logic [4:0][63:0] isd,
  input  logic [4:0][63:0] ise,
  output logic            can_take,
  output logic            ovalid,
  input  logic            oready,
  output logic [63:0]     odata,
  output logic [4:0]      olane,
  output logic            olast,
  output logic            overflow
);

  generate
    if (OUT_LANES < 1 || OUT_LANES > 25) begin : g_bad_out_lanes
      $error("sha3_digest_serializer: OUT_LANES must be in 1..25");
    end
  endgenerate

  localparam logic [4:0] LAST_IDX = 5'(OUT_LANES - 1);

  // Two state slots; data is not reset, validity is tracked by r_count
  logic [63:0] r_slot [2][OUT_LANES];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic [4:0]  r_idx;
  logic        r_overflow;

  logic [63:0] w_lane [OUT_LANES];
  logic [63:0] w_odata;
  logic        w_ovalid;
  logic        w_is_last;
  logic        w_fire;
  logic        w_free;
  logic        w_accept;
  logic        w_drop;
  logic        w_unused_rows;

  // Lanes beyond OUT_LANES are intentionally ignored; fold them so they do not dangle
  assign w_unused_rows = ^{isa, isb, isc, isd, ise};

  // Map lane index k to row k/5, element k%5 for the lanes we keep
  always_comb begin
    for (int k = 0; k < OUT_LANES; k++) begin
      w_lane[k] = '0;
      case (k / 5)
        0:       w_lane[k] = isa[3'(k % 5)];
        1:       w_lane[k] = isb[3'(k % 5)];
        2:       w_lane[k] = isc[3'(k % 5)];
        3:       w_lane[k] = isd[3'(k % 5)];
        default: w_lane[k] = ise[3'(k % 5)];
      endcase
    end
  end

  assign w_ovalid  = (r_count != 2'd0);
  assign w_is_last = (r_idx == LAST_IDX);
  assign w_fire    = w_ovalid & oready;
  assign w_free    = w_fire & w_is_last;
  // A freeing fire makes room in the same cycle, so a full buffer can still accept
  assign w_accept  = sample & ((r_count != 2'd2) | w_free);
  assign w_drop    = sample & ~w_accept;

  // Select the current lane of the oldest buffered state
  always_comb begin
    w_odata = '0;
    for (int k = 0; k < OUT_LANES; k++) begin
      if (r_idx == 5'(k)) w_odata = r_slot[r_rd_ptr][k];
    end
  end

  // Capture the kept lanes of an accepted state into the write slot
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < OUT_LANES; k++) begin
        r_slot[r_wr_ptr][k] <= w_lane[k];
      end
    end
  end

  // Pointers, occupancy, lane index and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_idx      <= 5'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= ~r_wr_ptr;
      if (w_drop)   r_overflow <= 1'b1;
      if (w_free) begin
        r_idx    <= 5'd0;
        r_rd_ptr <= ~r_rd_ptr;
      end else if (w_fire) begin
        r_idx <= r_idx + 5'd1;
      end
      case ({w_accept, w_free})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign can_take = (r_count != 2'd2);
  assign ovalid   = w_ovalid;
  assign odata    = w_odata;
  assign olane    = r_idx;
  assign olast    = w_ovalid & w_is_last;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_sha3_digest_serializer.sv
// tb/tb_sha3_digest_serializer.sv - directed self-checking bench for sha3_digest_serializer
module tb_sha3_digest_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [4:0][63:0] isa, isb, isc, isd, ise;

  logic sample4, sample1, sample25;
  logic oready4, oready1, oready25;
  logic can_take4, can_take1, can_take25;
  logic ovalid4, ovalid1, ovalid25;
  logic [63:0] odata4, odata1, odata25;
  logic [4:0] olane4, olane1, olane25;
  logic olast4, olast1, olast25;
  logic overflow4, overflow1, overflow25;

  sha3_digest_serializer #(.OUT_LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .sample(sample4),
    .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .can_take(can_take4), .ovalid(ovalid4), .oready(oready4),
    .odata(odata4), .olane(olane4), .olast(olast4), .overflow(overflow4)
  );

  sha3_digest_serializer #(.OUT_LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sample(sample1),
    .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .can_take(can_take1), .ovalid(ovalid1), .oready(oready1),
    .odata(odata1), .olane(olane1), .olast(olast1), .overflow(overflow1)
  );

  sha3_digest_serializer #(.OUT_LANES(25)) u_dut25 (
    .clk(clk), .rst_n(rst_n), .sample(sample25),
    .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .can_take(can_take25), .ovalid(ovalid25), .oready(oready25),
    .odata(odata25), .olane(olane25), .olast(olast25), .overflow(overflow25)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_state(input logic [63:0] base);
    for (int k = 0; k < 25; k++) begin
      case (k / 5)
        0:       isa[k % 5] = base + 64'(k);
        1:       isb[k % 5] = base + 64'(k);
        2:       isc[k % 5] = base + 64'(k);
        3:       isd[k % 5] = base + 64'(k);
        default: ise[k % 5] = base + 64'(k);
      endcase
    end
  endtask

  task automatic do_reset();
    sample4 = 1'b0; sample1 = 1'b0; sample25 = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  logic [6:0]  pat;
  logic [63:0] bases [3];
  int          e;

  initial begin
    rst_n = 1'b0;
    sample4 = 1'b0; sample1 = 1'b0; sample25 = 1'b0;
    oready4 = 1'b1; oready1 = 1'b1; oready25 = 1'b1;
    set_state(64'h0);
    #1;
    check_eq("reset_ovalid", ovalid4, 1'b0);
    check_eq("reset_olane", olane4, 5'd0);
    check_eq("reset_olast", olast4, 1'b0);
    check_eq("reset_overflow", overflow4, 1'b0);
    check_eq("reset_can_take", can_take4, 1'b1);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Single state, streaming with oready held high
    set_state(64'h1000);
    sample4 = 1'b1;
    step();
    sample4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq("s1_ovalid", ovalid4, 1'b1);
      check_eq("s1_odata", odata4, 64'h1000 + 64'(k));
      check_eq("s1_olane", olane4, 64'(k));
      check_eq("s1_olast", olast4, (k == 3));
      step();
    end
    check_eq("s1_ovalid_end", ovalid4, 1'b0);
    check_eq("s1_overflow", overflow4, 1'b0);

    // Backpressure pattern 0,1,0,0,1,1,1
    pat = 7'b1110010;
    oready4 = 1'b0;
    sample4 = 1'b1;
    step();
    sample4 = 1'b0;
    e = 0;
    for (int i = 0; i < 7; i++) begin
      oready4 = pat[i];
      check_eq("bp_ovalid", ovalid4, 1'b1);
      check_eq("bp_odata", odata4, 64'h1000 + 64'(e));
      check_eq("bp_olane", olane4, 64'(e));
      check_eq("bp_olast", olast4, (e == 3));
      if (pat[i]) e++;
      step();
    end
    check_eq("bp_ovalid_end", ovalid4, 1'b0);

    // Two samples on consecutive cycles stream without a bubble
    oready4 = 1'b1;
    set_state(64'hA0);
    sample4 = 1'b1;
    step();
    for (int j = 0; j < 8; j++) begin
      if (j == 0) begin
        set_state(64'hB0);
        sample4 = 1'b1;
      end else begin
        sample4 = 1'b0;
      end
      check_eq("b2b_ovalid", ovalid4, 1'b1);
      check_eq("b2b_odata", odata4, (j < 4 ? 64'hA0 : 64'hB0) + 64'(j % 4));
      check_eq("b2b_olast", olast4, (j % 4 == 3));
      check_eq("b2b_can_take", can_take4, !(j >= 1 && j <= 3));
      step();
    end
    check_eq("b2b_ovalid_end", ovalid4, 1'b0);
    check_eq("b2b_overflow", overflow4, 1'b0);

    // Overflow: third state dropped while consumer stalls
    oready4 = 1'b0;
    set_state(64'hA0); sample4 = 1'b1; step();
    set_state(64'hB0); step();
    check_eq("ovf_before", overflow4, 1'b0);
    check_eq("ovf_can_take", can_take4, 1'b0);
    set_state(64'hC0); step();
    sample4 = 1'b0;
    check_eq("ovf_set", overflow4, 1'b1);
    oready4 = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check_eq("ovf_ovalid", ovalid4, 1'b1);
      check_eq("ovf_odata", odata4, (j < 4 ? 64'hA0 : 64'hB0) + 64'(j % 4));
      step();
    end
    check_eq("ovf_ovalid_end", ovalid4, 1'b0);
    check_eq("ovf_sticky", overflow4, 1'b1);
    do_reset();
    check_eq("ovf_cleared", overflow4, 1'b0);

    // Sample in the exact cycle the full buffer frees a slot
    oready4 = 1'b0;
    set_state(64'hA0); sample4 = 1'b1; step();
    set_state(64'hB0); step();
    sample4 = 1'b0;
    oready4 = 1'b1;
    bases[0] = 64'hA0; bases[1] = 64'hB0; bases[2] = 64'hC0;
    for (int j = 0; j < 12; j++) begin
      if (j == 3) begin
        set_state(64'hC0);
        sample4 = 1'b1;
      end else begin
        sample4 = 1'b0;
      end
      check_eq("sim_ovalid", ovalid4, 1'b1);
      check_eq("sim_odata", odata4, bases[j / 4] + 64'(j % 4));
      check_eq("sim_olast", olast4, (j % 4 == 3));
      if (j == 4) check_eq("sim_can_take", can_take4, 1'b0);
      step();
    end
    check_eq("sim_ovalid_end", ovalid4, 1'b0);
    check_eq("sim_overflow", overflow4, 1'b0);

    // Reset asserted mid-stream
    set_state(64'hA0);
    sample4 = 1'b1;
    step();
    sample4 = 1'b0;
    step();
    step();
    check_eq("rst_pre_olane", olane4, 5'd2);
    rst_n = 1'b0;
    #1;
    check_eq("rst_ovalid", ovalid4, 1'b0);
    check_eq("rst_olast", olast4, 1'b0);
    check_eq("rst_olane", olane4, 5'd0);
    sample4 = 1'b1;
    repeat (2) step();
    sample4 = 1'b0;
    rst_n = 1'b1;
    step();
    check_eq("rst_ignored_sample", ovalid4, 1'b0);
    set_state(64'hD0);
    sample4 = 1'b1;
    step();
    sample4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq("rst_d_odata", odata4, 64'hD0 + 64'(k));
      check_eq("rst_d_olane", olane4, 64'(k));
      step();
    end
    check_eq("rst_d_overflow", overflow4, 1'b0);

    // OUT_LANES = 1: every word is last
    set_state(64'h1000);
    sample1 = 1'b1;
    step();
    check_eq("l1_ovalid0", ovalid1, 1'b1);
    check_eq("l1_odata0", odata1, 64'h1000);
    check_eq("l1_olast0", olast1, 1'b1);
    check_eq("l1_olane0", olane1, 5'd0);
    set_state(64'h2000);
    step();
    sample1 = 1'b0;
    check_eq("l1_odata1", odata1, 64'h2000);
    check_eq("l1_olast1", olast1, 1'b1);
    step();
    check_eq("l1_ovalid_end", ovalid1, 1'b0);
    check_eq("l1_overflow", overflow1, 1'b0);

    // OUT_LANES = 25: full state streamed, last on lane 24 only
    set_state(64'h1000);
    sample25 = 1'b1;
    step();
    sample25 = 1'b0;
    for (int k = 0; k < 25; k++) begin
      check_eq("l25_ovalid", ovalid25, 1'b1);
      check_eq("l25_odata", odata25, 64'h1000 + 64'(k));
      check_eq("l25_olane", olane25, 64'(k));
      check_eq("l25_olast", olast25, (k == 24));
      step();
    end
    check_eq("l25_ovalid_end", ovalid25, 1'b0);
    check_eq("l25_overflow", overflow25, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
